// File: rtl/amb_ext.sv
// amb_ext: accumulator CPU core with carry/zero flags, branches, HALT and a ready-handshaked data port
module amb_ext #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int OPCODE_W = 4,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   pc,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [ADDR_W-1:0]   operand,
    output logic                dreq,
    output logic                we,
    input  logic                dready,
    input  logic [DATA_W-1:0]   ddatain,
    output logic [DATA_W-1:0]   accum,
    output logic                carry,
    output logic                zero,
    output logic                halted
);
    typedef enum logic [1:0] {EXEC, WAIT, HALT} state_t;
    state_t state;
    logic [3:0] op;
    logic legal;
    logic is_mem;
    logic is_halt;
    logic wr_acc;
    logic c_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign op = opcode[3:0];
    assign legal = (opcode >> 4) == '0;
    assign is_mem = legal && op >= 4'h1 && op <= 4'h7;
    assign is_halt = legal && op == 4'hF;
    assign dreq = rst_n && state != HALT && is_mem;
    assign we = dreq && op == 4'h2;
    assign pc_inc = pc + ADDR_W'(1);
    assign sum = {1'b0, accum} + {1'b0, ddatain};
    assign diff = {1'b0, accum} - {1'b0, ddatain};

    // Result of the current instruction, committed only on the cycle it completes
    always_comb begin
        acc_nxt = accum;
        c_nxt = carry;
        pc_nxt = pc_inc;
        wr_acc = 1'b0;
        if (legal) begin
            case (op)
                4'h1: begin
                    acc_nxt = ddatain;
                    wr_acc = 1'b1;
                end
                4'h3: begin
                    {c_nxt, acc_nxt} = sum;
                    wr_acc = 1'b1;
                end
                4'h4: begin
                    {c_nxt, acc_nxt} = diff;
                    wr_acc = 1'b1;
                end
                4'h5: begin
                    acc_nxt = accum & ddatain;
                    c_nxt = 1'b0;
                    wr_acc = 1'b1;
                end
                4'h6: begin
                    acc_nxt = accum | ddatain;
                    c_nxt = 1'b0;
                    wr_acc = 1'b1;
                end
                4'h7: begin
                    acc_nxt = accum ^ ddatain;
                    c_nxt = 1'b0;
                    wr_acc = 1'b1;
                end
                4'h8: begin
                    {c_nxt, acc_nxt} = {accum, 1'b0};
                    wr_acc = 1'b1;
                end
                4'h9: begin
                    {acc_nxt, c_nxt} = {1'b0, accum};
                    wr_acc = 1'b1;
                end
                4'hA: begin
                    acc_nxt = DATA_W'(operand);
                    wr_acc = 1'b1;
                end
                4'hB: pc_nxt = operand;
                4'hC: pc_nxt = zero ? operand : pc_inc;
                4'hD: pc_nxt = carry ? operand : pc_inc;
                4'hE: pc_nxt = !zero ? operand : pc_inc;
                default: ;
            endcase
        end
    end

    // Sequencer: stall in WAIT until memory is ready, park in HALT until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EXEC;
            pc <= RST_PC;
            accum <= '0;
            carry <= 1'b0;
            zero <= 1'b0;
            halted <= 1'b0;
        end else if (state != HALT) begin
            if (is_halt) begin
                state <= HALT;
                halted <= 1'b1;
            end else if (is_mem && !dready) begin
                state <= WAIT;
            end else begin
                state <= EXEC;
                pc <= pc_nxt;
                accum <= acc_nxt;
                carry <= c_nxt;
                if (wr_acc) zero <= acc_nxt == '0;
            end
        end
    end
endmodule
